// File: rtl/spi_master_if.sv
// Host/pin bundle for spi_master: start/tx_data/rx_data/done handshake plus the SPI pins.
// The master modport is the spi_master side; the slave modport is whatever drives it (host and slave device).
interface spi_master_if #(
    parameter int BIT_LENGTH = 32
);
    logic                  start;
    logic [BIT_LENGTH-1:0] tx_data;
    logic                  miso;
    logic                  ss;
    logic                  sclk;
    logic                  mosi;
    logic                  busy;
    logic [BIT_LENGTH-1:0] rx_data;
    logic                  done;

    modport master (
        input  start, tx_data, miso,
        output ss, sclk, mosi, busy, rx_data, done
    );

    modport slave (
        output start, tx_data, miso,
        input  ss, sclk, mosi, busy, rx_data, done
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: one BIT_LENGTH-bit full-duplex word per start, every output registered.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order (default build is MSB first).
module spi_master #(
    parameter int BIT_LENGTH   = 32,
    parameter int COUNT_LENGTH = 6,
    parameter int HALF_PERIOD  = 4,
    parameter int DIV_WIDTH    = 8
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [DIV_WIDTH-1:0]    div_reg, div_next;
    logic [COUNT_LENGTH-1:0] bit_cnt_reg, bit_cnt_next;
    logic [BIT_LENGTH-1:0]   tx_sh_reg, tx_sh_next;
    logic [BIT_LENGTH-1:0]   rx_sh_reg, rx_sh_next;
    logic [BIT_LENGTH-1:0]   rx_data_reg, rx_data_next;
    logic                    ss_reg, ss_next;
    logic                    sclk_reg, sclk_next;
    logic                    mosi_reg, mosi_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    logic                    div_done;
    logic                    more_bits;
    logic                    first_bit;
    logic                    next_bit;
    logic [BIT_LENGTH-1:0]   tx_shifted;
    logic [BIT_LENGTH-1:0]   rx_shifted;

    assign div_done  = (div_reg == DIV_WIDTH'(HALF_PERIOD - 1));
    assign more_bits = (bit_cnt_reg < COUNT_LENGTH'(BIT_LENGTH));

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign first_bit  = bus.tx_data[0];
    assign next_bit   = tx_sh_reg[1];
    assign tx_shifted = {1'b0, tx_sh_reg[BIT_LENGTH-1:1]};
    assign rx_shifted = {bus.miso, rx_sh_reg[BIT_LENGTH-1:1]};
`else
    assign first_bit  = bus.tx_data[BIT_LENGTH-1];
    assign next_bit   = tx_sh_reg[BIT_LENGTH-2];
    assign tx_shifted = {tx_sh_reg[BIT_LENGTH-2:0], 1'b0};
    assign rx_shifted = {rx_sh_reg[BIT_LENGTH-2:0], bus.miso};
`endif

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_sh_next   = tx_sh_reg;
        rx_sh_next   = rx_sh_reg;
        rx_data_next = rx_data_reg;
        ss_next      = ss_reg;
        sclk_next    = sclk_reg;
        mosi_next    = mosi_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                div_next     = '0;
                bit_cnt_next = '0;
                if (bus.start) begin
                    tx_sh_next = bus.tx_data;
                    rx_sh_next = '0;
                    ss_next    = 1'b0;
                    busy_next  = 1'b1;
                    mosi_next  = first_bit;
                    state_next = LEAD;
                end
            end
            LEAD: begin
                if (div_done) begin
                    div_next     = '0;
                    sclk_next    = 1'b1;
                    rx_sh_next   = rx_shifted;
                    bit_cnt_next = bit_cnt_reg + COUNT_LENGTH'(1);
                    state_next   = HIGH;
                end else begin
                    div_next = div_reg + DIV_WIDTH'(1);
                end
            end
            HIGH: begin
                if (div_done) begin
                    div_next   = '0;
                    sclk_next  = 1'b0;
                    state_next = LOW;
                    // After the last rising edge mosi simply holds until the word closes.
                    if (more_bits) begin
                        tx_sh_next = tx_shifted;
                        mosi_next  = next_bit;
                    end
                end else begin
                    div_next = div_reg + DIV_WIDTH'(1);
                end
            end
            LOW: begin
                if (div_done) begin
                    div_next = '0;
                    if (more_bits) begin
                        sclk_next    = 1'b1;
                        rx_sh_next   = rx_shifted;
                        bit_cnt_next = bit_cnt_reg + COUNT_LENGTH'(1);
                        state_next   = HIGH;
                    end else begin
                        ss_next      = 1'b1;
                        done_next    = 1'b1;
                        rx_data_next = rx_sh_reg;
                        mosi_next    = 1'b0;
                        state_next   = GAP;
                    end
                end else begin
                    div_next = div_reg + DIV_WIDTH'(1);
                end
            end
            GAP: begin
                // Holds ss high long enough for the slave to re-arm between words.
                if (div_done) begin
                    div_next   = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    div_next = div_reg + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_cnt_reg <= '0;
            tx_sh_reg   <= '0;
            rx_sh_reg   <= '0;
            rx_data_reg <= '0;
            ss_reg      <= 1'b1;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_sh_reg   <= tx_sh_next;
            rx_sh_reg   <= rx_sh_next;
            rx_data_reg <= rx_data_next;
            ss_reg      <= ss_next;
            sclk_reg    <= sclk_next;
            mosi_reg    <= mosi_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign bus.ss      = ss_reg;
    assign bus.sclk    = sclk_reg;
    assign bus.mosi    = mosi_reg;
    assign bus.busy    = busy_reg;
    assign bus.rx_data = rx_data_reg;
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback and a bit-indexed slave model, with latency, edge-count and handshake checks.
// Honors SPI_MASTER_LSB_FIRST_EN for the expected bit order.
module tb_spi_master;
    localparam int B       = 32;
    localparam int H       = 4;
    localparam int LAT     = H * (2 * B + 1);
    localparam int SPACING = LAT + H + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_if #(.BIT_LENGTH(B)) bus ();

    spi_master #(
        .BIT_LENGTH(B), .COUNT_LENGTH(6), .HALF_PERIOD(H), .DIV_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Position in the word of the i-th bit on the wire.
    function automatic int bit_pos(input int i);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return i;
`else
        return B - 1 - i;
`endif
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   done_cnt = 0;
    int   last_done_cyc = -1;
    int   rise_cnt = 0;
    logic mon_sclk_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (bus.sclk && !mon_sclk_prev && !bus.ss) rise_cnt++;
        mon_sclk_prev = bus.sclk;
    end

    // Clk-synchronous slave: sends slave_word bit by bit, captures mosi into slave_cap.
    logic         loopback = 1'b1;
    logic [B-1:0] slave_word = '0;
    logic [B-1:0] slave_cap = '0;
    int           s_tx_idx = 0;
    int           s_rx_idx = 0;
    logic         s_sclk_prev = 1'b0;
    logic         slave_miso;

    always @(posedge clk) begin
        s_sclk_prev <= bus.sclk;
        if (bus.ss) begin
            s_tx_idx <= 0;
            s_rx_idx <= 0;
        end else begin
            if (bus.sclk && !s_sclk_prev) begin
                if (s_rx_idx < B) slave_cap[bit_pos(s_rx_idx)] <= bus.mosi;
                s_rx_idx <= s_rx_idx + 1;
            end
            if (!bus.sclk && s_sclk_prev) s_tx_idx <= s_tx_idx + 1;
        end
    end

    always_comb begin
        slave_miso = 1'b0;
        if (s_tx_idx < B) slave_miso = slave_word[bit_pos(s_tx_idx)];
    end

    assign bus.miso = loopback ? bus.mosi : slave_miso;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_word(input logic [B-1:0] tx, output int k);
        bus.tx_data = tx;
        bus.start   = 1'b1;
        tick();
        k = cyc;
        bus.start = 1'b0;
        check("accept busy", bus.busy, 1'b1);
        check("accept ss", bus.ss, 1'b0);
        check("first mosi", bus.mosi, tx[bit_pos(0)]);
    endtask

    task automatic wait_done(input int base, output bit ok);
        int n = 0;
        while (done_cnt == base && n < 2000) begin
            tick();
            n++;
        end
        ok = (done_cnt != base);
        if (!ok) check("done timeout", 1'b0, 1'b1);
    endtask

    task automatic transact(input string tag, input logic [B-1:0] tx, input logic lb,
                            input logic [B-1:0] sw);
        int k;
        int base;
        bit ok;
        logic [B-1:0] exp_rx;
        loopback   = lb;
        slave_word = sw;
        exp_rx     = lb ? tx : sw;
        base       = done_cnt;
        rise_cnt   = 0;
        start_word(tx, k);
        wait_done(base, ok);
        if (ok) begin
            check({tag, " rx"}, bus.rx_data, exp_rx);
            check({tag, " latency"}, last_done_cyc - k, LAT);
            check({tag, " ss at done"}, bus.ss, 1'b1);
        end
        repeat (H + 2) tick();
        check({tag, " done count"}, done_cnt - base, 1);
        check({tag, " sclk rises"}, rise_cnt, B);
        check({tag, " idle busy"}, bus.busy, 1'b0);
        if (!lb) check({tag, " slave cap"}, slave_cap, tx);
        $display("txn %s tx=%08h miso_word=%08h rx=%08h", tag, tx, exp_rx, bus.rx_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int base;
        int d_prev;
        bit ok;
        logic [B-1:0] w;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset ss", bus.ss, 1'b1);
        check("reset sclk", bus.sclk, 1'b0);
        check("reset mosi", bus.mosi, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset rx", bus.rx_data, '0);

        transact("loop_a5", 32'hA5A5_F00F, 1'b1, '0);
        transact("slave_dead", 32'h1234_5678, 1'b0, 32'hDEAD_BEEF);
        transact("one", 32'h0000_0001, 1'b1, '0);

        // Second start and tx_data change mid-word must be ignored.
        loopback = 1'b1;
        base     = done_cnt;
        start_word(32'hC3C3_0FF0, k);
        while (cyc < k + 49) tick();
        bus.start   = 1'b1;
        bus.tx_data = 32'h5555_AAAA;
        tick();
        bus.start   = 1'b0;
        bus.tx_data = 32'h0F0F_0F0F;
        wait_done(base, ok);
        if (ok) check("ignore rx", bus.rx_data, 32'hC3C3_0FF0);
        repeat (H + 3) tick();
        check("ignore done count", done_cnt - base, 1);
        $display("txn ignore tx=c3c30ff0 rx=%08h", bus.rx_data);

        // Reset in the middle of a word.
        base = done_cnt;
        start_word(32'hFFFF_FFFF, k);
        while (cyc < k + 99) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset ss", bus.ss, 1'b1);
        check("midreset sclk", bus.sclk, 1'b0);
        check("midreset mosi", bus.mosi, 1'b0);
        check("midreset busy", bus.busy, 1'b0);
        check("midreset rx", bus.rx_data, '0);
        repeat (LAT + 20) tick();
        check("midreset no done", done_cnt - base, 0);
        $display("txn midreset aborted rx=%08h", bus.rx_data);
        transact("after_reset", 32'h8000_0001, 1'b1, '0);

        // start held high across three words.
        loopback    = 1'b1;
        bus.tx_data = 32'h1;
        bus.start   = 1'b1;
        d_prev      = -1;
        for (int i = 1; i <= 3; i++) begin
            base = done_cnt;
            wait_done(base, ok);
            if (i == 3) bus.start = 1'b0;
            bus.tx_data = B'(i + 1);
            if (ok) begin
                check($sformatf("held rx %0d", i), bus.rx_data, B'(i));
                if (d_prev >= 0) check($sformatf("held spacing %0d", i), last_done_cyc - d_prev, SPACING);
                d_prev = last_done_cyc;
            end
            $display("txn held word %0d rx=%08h", i, bus.rx_data);
        end
        repeat (H + 3) tick();
        check("held idle", bus.busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            transact($sformatf("rand_loop%0d", i), w, 1'b1, '0);
        end
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            transact($sformatf("rand_slave%0d", i), w, 1'b0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
